// File: rtl/iicmb_wb_sequencer.sv
// iicmb_wb_sequencer
// Drives the IICMB I2C controller through its Wishbone slave port so that a
// requester can run a whole I2C transfer with one handshake.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cyc_o..dat_o, dat_i,    Wishbone master (single cycles, adr 0 CSR,
//   ack_i                   1 DPR, 2 CMDR)
//   irq_i                   IICMB command-complete interrupt
//   req_*                   transfer request (bus, addr, rd, len), valid/ready
//   wr_valid/ready/data     write-byte stream into the sequencer
//   rd_valid/rd_data        received-byte pulses
//   done/status             completion pulse, 00 OK 01 addr NAK 10 data NAK
//                           11 arbitration lost / error / irq timeout
module iicmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 8,
  parameter int IRQ_TIMEOUT    = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [3:0]                req_bus,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_rd,
  input  logic [LEN_WIDTH-1:0]      req_len,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [7:0]                wr_data,
  output logic                      rd_valid,
  output logic [7:0]                rd_data,
  output logic                      done,
  output logic [1:0]                status
);

  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);
  localparam logic [2:0] C_WR = 3'h1, C_RDA = 3'h2, C_RDN = 3'h3,
                         C_START = 3'h4, C_STOP = 3'h5, C_BUS = 3'h6;
  localparam int CW = $clog2(IRQ_TIMEOUT + 1);

  typedef enum logic [4:0] {
    S_INIT, S_IDLE, S_WB, S_BUS_D, S_BUS_C, S_START, S_ADDR_D, S_ADDR_C,
    S_WR_FETCH, S_WR_D, S_WR_C, S_RD_C, S_RD_D, S_RD_GOT, S_STOP,
    S_WAIT, S_EVAL, S_DONE
  } state_t;

  state_t                    r_state, r_ret;
  logic [3:0]                r_bus;
  logic [I2C_ADDR_WIDTH-1:0] r_addr;
  logic                      r_rd;
  logic [LEN_WIDTH-1:0]      r_left;
  logic [7:0]                r_byte;
  logic [1:0]                r_code;
  logic [2:0]                r_cmd;
  logic                      r_addr_ph;
  logic                      r_nak, r_fail;
  logic [CW-1:0]             r_cnt;

  // Wishbone op requested by the current state (one op per state).
  logic                     w_go, w_we;
  logic [WB_ADDR_WIDTH-1:0] w_adr;
  logic [WB_DATA_WIDTH-1:0] w_dat;
  state_t                   w_ret;

  always_comb begin
    w_go  = 1'b1;
    w_we  = 1'b1;
    w_adr = A_CMDR;
    w_dat = '0;
    w_ret = S_WAIT;
    case (r_state)
      S_INIT:   begin w_adr = A_CSR; w_dat = WB_DATA_WIDTH'(8'hC0); w_ret = S_IDLE; end
      S_BUS_D:  begin w_adr = A_DPR; w_dat = WB_DATA_WIDTH'(r_bus); w_ret = S_BUS_C; end
      S_BUS_C:  w_dat = WB_DATA_WIDTH'(C_BUS);
      S_START:  w_dat = WB_DATA_WIDTH'(C_START);
      S_ADDR_D: begin w_adr = A_DPR; w_dat = WB_DATA_WIDTH'({r_addr, r_rd}); w_ret = S_ADDR_C; end
      S_ADDR_C: w_dat = WB_DATA_WIDTH'(C_WR);
      S_WR_D:   begin w_adr = A_DPR; w_dat = WB_DATA_WIDTH'(r_byte); w_ret = S_WR_C; end
      S_WR_C:   w_dat = WB_DATA_WIDTH'(C_WR);
      // last byte is read with NAK so the slave releases the bus
      S_RD_C:   w_dat = WB_DATA_WIDTH'((r_left == LEN_WIDTH'(1)) ? C_RDN : C_RDA);
      S_RD_D:   begin w_we = 1'b0; w_adr = A_DPR; w_ret = S_RD_GOT; end
      S_STOP:   w_dat = WB_DATA_WIDTH'(C_STOP);
      // reading CMDR both clears irq and returns the completion flags
      S_WAIT:   begin w_go = irq_i; w_we = 1'b0; w_ret = S_EVAL; end
      default:  w_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_INIT; r_ret <= S_IDLE;
      cyc_o <= 1'b0; stb_o <= 1'b0; we_o <= 1'b0; adr_o <= '0; dat_o <= '0;
      req_ready <= 1'b0; wr_ready <= 1'b0; rd_valid <= 1'b0; rd_data <= '0;
      done <= 1'b0; status <= 2'b00;
      r_bus <= '0; r_addr <= '0; r_rd <= 1'b0; r_left <= '0; r_byte <= '0;
      r_code <= 2'b00; r_cmd <= '0; r_addr_ph <= 1'b0; r_nak <= 1'b0;
      r_fail <= 1'b0; r_cnt <= '0;
    end else begin
      rd_valid <= 1'b0;
      wr_ready <= 1'b0;
      done     <= 1'b0;
      if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
      if (w_go) begin
        cyc_o <= 1'b1; stb_o <= 1'b1; we_o <= w_we; adr_o <= w_adr; dat_o <= w_dat;
        r_ret <= w_ret; r_state <= S_WB;
        // the irq timeout runs from the moment a command is issued
        if (w_we && w_adr == A_CMDR) begin
          r_cnt <= '0;
          r_cmd <= w_dat[2:0];
          r_addr_ph <= (r_state == S_ADDR_C);
        end
      end else begin
        case (r_state)
          S_WB: if (ack_i) begin
            cyc_o <= 1'b0; stb_o <= 1'b0; we_o <= 1'b0; adr_o <= '0; dat_o <= '0;
            r_state <= r_ret;
            if (r_ret == S_EVAL) begin
              r_nak  <= dat_i[6];
              r_fail <= dat_i[5] | dat_i[4];
            end
            if (r_ret == S_RD_GOT) begin
              rd_valid <= 1'b1;
              rd_data  <= dat_i[7:0];
            end
          end
          S_IDLE: begin
            if (req_ready && req_valid) begin
              req_ready <= 1'b0;
              r_bus <= req_bus; r_addr <= req_addr; r_rd <= req_rd; r_left <= req_len;
              r_code <= 2'b00;
              r_state <= S_BUS_D;
            end else begin
              req_ready <= 1'b1;
            end
          end
          S_WAIT: if (r_cnt >= CW'(IRQ_TIMEOUT)) begin
            r_code <= 2'b11;
            r_state <= S_DONE;
          end
          S_EVAL: begin
            if (r_fail) begin
              r_code <= 2'b11;
              r_state <= S_DONE;
            end else begin
              case (r_cmd)
                C_BUS:   r_state <= S_START;
                C_START: r_state <= S_ADDR_D;
                C_WR: begin
                  if (r_addr_ph) begin
                    if (r_nak) begin r_code <= 2'b01; r_state <= S_STOP; end
                    else if (r_left == '0) r_state <= S_STOP;
                    else r_state <= r_rd ? S_RD_C : S_WR_FETCH;
                  end else if (r_nak) begin
                    r_code <= 2'b10; r_state <= S_STOP;
                  end else begin
                    r_left <= r_left - LEN_WIDTH'(1);
                    r_state <= (r_left == LEN_WIDTH'(1)) ? S_STOP : S_WR_FETCH;
                  end
                end
                // NAK after read/NAK is the normal end of a read
                C_RDA, C_RDN: r_state <= S_RD_D;
                default: r_state <= S_DONE;
              endcase
            end
          end
          S_WR_FETCH: if (wr_valid) begin
            wr_ready <= 1'b1;
            r_byte <= wr_data;
            r_state <= S_WR_D;
          end
          S_RD_GOT: begin
            r_left <= r_left - LEN_WIDTH'(1);
            r_state <= (r_left == LEN_WIDTH'(1)) ? S_STOP : S_RD_C;
          end
          S_DONE: begin
            done <= 1'b1;
            status <= r_code;
            r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
